// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs1_ID;
   logic [4:0]       rs2_ID;
   logic             uses_rs1_ID;
   logic             uses_rs2_ID;
   logic [4:0]       wrin_EX;
   logic [4:0]       wrin_MEM;
   logic             RegWrite_EX;
   logic             RegWrite_MEM;
   logic             MemRead_EX;
   logic             MemRead_MEM;
   logic             MemWrite_MEM;
   logic             branch_taken_EX;
   logic             dmem_ready;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             dmem_req;
   logic             mem_error;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, wrin_EX, wrin_MEM,
             RegWrite_EX, RegWrite_MEM, MemRead_EX, MemRead_MEM, MemWrite_MEM,
             branch_taken_EX, dmem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
             id_ex_flush, dmem_req, mem_error, state, stall_cycles
   );

   modport slave (
      input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, wrin_EX, wrin_MEM,
             RegWrite_EX, RegWrite_MEM, MemRead_EX, MemRead_MEM, MemWrite_MEM,
             branch_taken_EX, dmem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
             id_ex_flush, dmem_req, mem_error, state, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch flushes and the data-memory
// wait FSM with timeout. Optional macro FORWARDING_EN limits data hazards to load-use.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic         CLK,
   input  logic         RESET_N,
   hazard_ctrl_if.slave hz
);
   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_nxt_s;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              dep_ex_s;
   logic              dep_mem_s;
   logic              data_hazard_s;
   logic              mem_access_s;
   logic              dmem_req_s;
   logic              mem_error_s;
   // Control vectors are {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   logic [6:0]        prio_ctrl_s;
   logic [6:0]        ctrl_s;

   function automatic logic id_depends(input logic [4:0] rs1, input logic use1,
                                       input logic [4:0] rs2, input logic use2,
                                       input logic [4:0] rd);
      return (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

   assign dep_ex_s     = id_depends(hz.rs1_ID, hz.uses_rs1_ID, hz.rs2_ID, hz.uses_rs2_ID, hz.wrin_EX);
   assign dep_mem_s    = id_depends(hz.rs1_ID, hz.uses_rs1_ID, hz.rs2_ID, hz.uses_rs2_ID, hz.wrin_MEM);
   assign mem_access_s = hz.MemRead_MEM | hz.MemWrite_MEM;

`ifdef FORWARDING_EN
   logic unused_fwd_s;
   assign data_hazard_s = hz.MemRead_EX & hz.RegWrite_EX & dep_ex_s;
   assign unused_fwd_s  = &{1'b0, dep_mem_s, hz.RegWrite_MEM};
`else
   logic unused_nofwd_s;
   // Without bypass paths any in-flight producer of a source register must drain first
   assign data_hazard_s  = (dep_ex_s & hz.RegWrite_EX) | (dep_mem_s & hz.RegWrite_MEM);
   assign unused_nofwd_s = &{1'b0, hz.MemRead_EX};
`endif

   // Branch / data-hazard / normal priority shared by RUN and the MEM_WAIT release cycle
   always_comb begin
      prio_ctrl_s = 7'b11111_00;
      if (hz.branch_taken_EX) begin
         prio_ctrl_s = 7'b11111_11;
      end else if (data_hazard_s) begin
         prio_ctrl_s = 7'b00111_01;
      end else begin
         prio_ctrl_s = 7'b11111_00;
      end
   end

   // Sequencing FSM: next state, wait counter and all control outputs
   always_comb begin
      ctrl_s         = 7'b00000_00;
      dmem_req_s     = 1'b0;
      mem_error_s    = 1'b0;
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      if (!RESET_N) begin
         state_nxt_s    = RUN;
         wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end else begin
         case (state_r)
            RUN: begin
               dmem_req_s = mem_access_s;
               if (mem_access_s && !hz.dmem_ready) begin
                  state_nxt_s    = MEM_WAIT;
                  wait_cnt_nxt_s = {WAIT_W{1'b0}};
               end else begin
                  ctrl_s = prio_ctrl_s;
               end
            end
            MEM_WAIT: begin
               dmem_req_s = 1'b1;
               if (hz.dmem_ready) begin
                  ctrl_s         = prio_ctrl_s;
                  wait_cnt_nxt_s = {WAIT_W{1'b0}};
                  state_nxt_s    = RUN;
               end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
                  state_nxt_s = ERROR;
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
               end
            end
            ERROR: begin
               mem_error_s = 1'b1;
            end
            default: begin
               state_nxt_s = ERROR;
            end
         endcase
      end
   end

   // State and wait-counter registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r    <= RUN;
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Saturating count of cycles in which the PC is held
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (!ctrl_s[6] && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign hz.pc_en        = ctrl_s[6];
   assign hz.if_id_en     = ctrl_s[5];
   assign hz.id_ex_en     = ctrl_s[4];
   assign hz.ex_mem_en    = ctrl_s[3];
   assign hz.mem_wb_en    = ctrl_s[2];
   assign hz.if_id_flush  = ctrl_s[1];
   assign hz.id_ex_flush  = ctrl_s[0];
   assign hz.dmem_req     = dmem_req_s;
   assign hz.mem_error    = mem_error_s;
   assign hz.state        = state_r;
   assign hz.stall_cycles = stall_cnt_r;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4 and a 4-bit stall counter.
module tb_hazard_ctrl;
   localparam int CNT_W = 4;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, dmem_req}
   localparam logic [7:0] V_OFF    = 8'b00000_00_0;
   localparam logic [7:0] V_IDLE   = 8'b11111_00_0;
   localparam logic [7:0] V_IDLE_R = 8'b11111_00_1;
   localparam logic [7:0] V_STALL  = 8'b00111_01_0;
   localparam logic [7:0] V_STALLR = 8'b00111_01_1;
   localparam logic [7:0] V_BRANCH = 8'b11111_11_0;
   localparam logic [7:0] V_BRANCHR= 8'b11111_11_1;
   localparam logic [7:0] V_FREEZE = 8'b00000_00_1;

   logic clk = 1'b0;
   logic rst_n;
   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   exp_stall = 0;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (.CLK(clk), .RESET_N(rst_n), .hz(hz));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctl_vec();
      return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
              hz.if_id_flush, hz.id_ex_flush, hz.dmem_req};
   endfunction

   task automatic idle();
      hz.rs1_ID = 5'd0;  hz.rs2_ID = 5'd0;  hz.uses_rs1_ID = 1'b0; hz.uses_rs2_ID = 1'b0;
      hz.wrin_EX = 5'd0; hz.wrin_MEM = 5'd0; hz.RegWrite_EX = 1'b0; hz.RegWrite_MEM = 1'b0;
      hz.MemRead_EX = 1'b0; hz.MemRead_MEM = 1'b0; hz.MemWrite_MEM = 1'b0;
      hz.branch_taken_EX = 1'b0; hz.dmem_ready = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bump();
      exp_stall = (exp_stall == 15) ? 15 : exp_stall + 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      hz.branch_taken_EX = 1'b1;
      hz.MemRead_MEM = 1'b1;
      hz.dmem_ready = 1'b0;
      #2;
      check_val("rst_ctl", 32'(ctl_vec()), 32'(V_OFF));
      check_val("rst_err", 32'(hz.mem_error), 32'd0);
      check_val("rst_state", 32'(hz.state), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_stall", 32'(hz.stall_cycles), 32'd0);
      check_val("rst_state_hold", 32'(hz.state), 32'd0);

      idle();
      rst_n = 1'b1;
      #1 check_val("idle", 32'(ctl_vec()), 32'(V_IDLE));
      tick();
      check_val("idle_stall", 32'(hz.stall_cycles), 32'd0);

      // lw x5 in EX, add x6,x5,x1 in ID
      hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1; hz.wrin_EX = 5'd5;
      hz.rs1_ID = 5'd5; hz.uses_rs1_ID = 1'b1; hz.rs2_ID = 5'd1; hz.uses_rs2_ID = 1'b1;
      #1 check_val("load_use", 32'(ctl_vec()), 32'(V_STALL));
      tick(); bump();
      check_val("load_use_cnt", 32'(hz.stall_cycles), 32'(exp_stall));

      hz.branch_taken_EX = 1'b1;
      #1 check_val("branch_over_lu", 32'(ctl_vec()), 32'(V_BRANCH));
      tick();
      check_val("branch_cnt", 32'(hz.stall_cycles), 32'(exp_stall));

      idle();
      hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1; hz.wrin_EX = 5'd0;
      hz.rs1_ID = 5'd0; hz.uses_rs1_ID = 1'b1;
      #1 check_val("x0_ex", 32'(ctl_vec()), 32'(V_IDLE));
      tick();

      idle();
      hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1; hz.wrin_EX = 5'd5;
      hz.rs1_ID = 5'd5; hz.uses_rs1_ID = 1'b0;
      #1 check_val("rs_unused", 32'(ctl_vec()), 32'(V_IDLE));
      tick();

      // addi x3 in MEM, sub x4,x3,x0 in ID
      idle();
      hz.RegWrite_MEM = 1'b1; hz.wrin_MEM = 5'd3;
      hz.rs1_ID = 5'd3; hz.uses_rs1_ID = 1'b1; hz.rs2_ID = 5'd0; hz.uses_rs2_ID = 1'b1;
      #1 check_val("raw_mem", 32'(ctl_vec()), FWD ? 32'(V_IDLE) : 32'(V_STALL));
      tick();
      if (!FWD) bump();

      // ALU producer in EX matched on rs2
      idle();
      hz.RegWrite_EX = 1'b1; hz.wrin_EX = 5'd7; hz.rs2_ID = 5'd7; hz.uses_rs2_ID = 1'b1;
      #1 check_val("raw_ex_rs2", 32'(ctl_vec()), FWD ? 32'(V_IDLE) : 32'(V_STALL));
      tick();
      if (!FWD) bump();

      idle();
      hz.RegWrite_MEM = 1'b1; hz.wrin_MEM = 5'd0; hz.rs1_ID = 5'd0; hz.uses_rs1_ID = 1'b1;
      #1 check_val("x0_mem", 32'(ctl_vec()), 32'(V_IDLE));
      tick();
      check_val("raw_cnt", 32'(hz.stall_cycles), 32'(exp_stall));

      // zero-wait memory
      idle();
      hz.MemRead_MEM = 1'b1; hz.dmem_ready = 1'b1;
      #1 check_val("mem_zero_wait", 32'(ctl_vec()), 32'(V_IDLE_R));
      tick();
      check_val("mem_zero_state", 32'(hz.state), 32'd0);

      // ready low for 3 cycles, branch pending on release
      hz.dmem_ready = 1'b0; hz.branch_taken_EX = 1'b1;
      #1 check_val("freeze_run", 32'(ctl_vec()), 32'(V_FREEZE));
      tick(); bump();
      for (int i = 0; i < 2; i++) begin
         check_val("wait_state", 32'(hz.state), 32'd1);
         check_val("wait_ctl", 32'(ctl_vec()), 32'(V_FREEZE));
         tick(); bump();
      end
      hz.dmem_ready = 1'b1;
      #1 check_val("release_branch", 32'(ctl_vec()), 32'(V_BRANCHR));
      check_val("release_state", 32'(hz.state), 32'd1);
      tick();
      check_val("back_run", 32'(hz.state), 32'd0);

      // store freeze with load-use resolved on the release cycle
      idle();
      hz.MemWrite_MEM = 1'b1; hz.dmem_ready = 1'b0;
      hz.MemRead_EX = 1'b1; hz.RegWrite_EX = 1'b1; hz.wrin_EX = 5'd9;
      hz.rs2_ID = 5'd9; hz.uses_rs2_ID = 1'b1;
      #1 check_val("freeze_over_lu", 32'(ctl_vec()), 32'(V_FREEZE));
      tick(); bump();
      hz.dmem_ready = 1'b1;
      #1 check_val("release_lu", 32'(ctl_vec()), 32'(V_STALLR));
      tick(); bump();
      check_val("release_lu_cnt", 32'(hz.stall_cycles), 32'(exp_stall));

      // timeout: 5 non-ready wait cycles with MEM_TIMEOUT=4
      idle();
      hz.MemWrite_MEM = 1'b1; hz.dmem_ready = 1'b0;
      #1; tick(); bump();
      for (int i = 0; i < 5; i++) begin
         check_val("to_wait_state", 32'(hz.state), 32'd1);
         tick(); bump();
      end
      check_val("to_error", 32'(hz.state), 32'd2);
      check_val("to_cnt", 32'(hz.stall_cycles), 32'(exp_stall));
      hz.dmem_ready = 1'b1; hz.branch_taken_EX = 1'b1;
      #1 check_val("err_ctl", 32'(ctl_vec()), 32'(V_OFF));
      check_val("err_flag", 32'(hz.mem_error), 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick(); bump();
      end
      check_val("err_hold", 32'(hz.state), 32'd2);
      check_val("stall_sat", 32'(hz.stall_cycles), 32'(exp_stall));

      // async reset out of ERROR
      rst_n = 1'b0;
      #1 check_val("areset_err_state", 32'(hz.state), 32'd0);
      check_val("areset_err_flag", 32'(hz.mem_error), 32'd0);
      check_val("areset_err_cnt", 32'(hz.stall_cycles), 32'd0);
      idle();
      tick();
      rst_n = 1'b1;
      #1 check_val("after_reset", 32'(ctl_vec()), 32'(V_IDLE));

      // async reset out of MEM_WAIT
      tick();
      hz.MemRead_MEM = 1'b1; hz.dmem_ready = 1'b0;
      tick();
      check_val("wait_again", 32'(hz.state), 32'd1);
      rst_n = 1'b0;
      #1 check_val("areset_wait", 32'(hz.state), 32'd0);
      idle();
      tick();
      rst_n = 1'b1;
      tick();
      check_val("final_state", 32'(hz.state), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
